// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width, idle line level
// and the parity helper used when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int   UART_DATA_W = 8;
  localparam logic LINE_IDLE   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic calc_parity(input logic [UART_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_buf.sv
// One-entry valid/ready holding register between the byte source and the
// transmit shifter; in_ready is low whenever the entry is occupied.
module uart_tx_buf
  import uart_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [UART_DATA_W-1:0] in_data,
  output logic                   in_ready,
  input  logic                   unload,
  output logic                   out_full,
  output logic [UART_DATA_W-1:0] out_data
);

  logic                   full_q, full_d;
  logic [UART_DATA_W-1:0] data_q, data_d;

  // next entry contents: capture on handshake, clear on unload
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (in_valid && !full_q) begin
      full_d = 1'b1;
      data_d = in_data;
    end else if (unload) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign in_ready = ~full_q;
  assign out_full = full_q;
  assign out_data = data_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, STOP_BITS
// stop bits, one bit per enable_clk tick. Parity bit present when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_clk,
  input  logic                   tx_valid,
  input  logic [UART_DATA_W-1:0] tx_data,
  output logic                   tx_ready,
  output logic                   tx,
  output logic                   tx_busy,
  output logic                   tx_done
);

  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  uart_state_e            state_q, state_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   unload_s;
  logic                   buf_full_s;
  logic [UART_DATA_W-1:0] buf_data_s;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  uart_tx_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (tx_valid),
    .in_data  (tx_data),
    .in_ready (tx_ready),
    .unload   (unload_s),
    .out_full (buf_full_s),
    .out_data (buf_data_s)
  );

  // frame sequencing; line level is derived from the next state so tx is registered
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    unload_s = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable_clk && buf_full_s) begin
          unload_s = 1'b1;
          state_d  = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (enable_clk) begin
          state_d = ST_DATA;
          cnt_d   = 3'd0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (enable_clk) begin
          shreg_d = shreg_q >> 1;
          if (cnt_q == 3'd7) begin
            cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (enable_clk) begin
          state_d = ST_STOP;
          cnt_d   = 3'd0;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (enable_clk) begin
          if (cnt_q == STOP_LAST) begin
            done_d = 1'b1;
            cnt_d  = 3'd0;
            // a waiting byte starts with no idle gap
            if (buf_full_s) begin
              unload_s = 1'b1;
              state_d  = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    if (unload_s) begin
      shreg_d = buf_data_s;
`ifdef UART_TX_PARITY_EN
      par_d   = calc_parity(buf_data_s, PARITY_ODD);
`endif
    end else begin
      shreg_d = shreg_d;
    end

    case (state_d)
      ST_IDLE:   tx_d = LINE_IDLE;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = LINE_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // state, shifter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= 3'd0;
      tx_q    <= LINE_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: instance u1 uses STOP_BITS=1/even parity,
// instance u2 uses STOP_BITS=2/odd parity. Parity checks follow UART_TX_PARITY_EN.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_clk = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_valid2 = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready1, tx1, tx_busy1, tx_done1;
  logic       tx_ready2, tx2, tx_busy2, tx_done2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.STOP_BITS(1), .PARITY_ODD(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .enable_clk(enable_clk), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready1), .tx(tx1), .tx_busy(tx_busy1), .tx_done(tx_done1)
  );

  uart_tx #(.STOP_BITS(2), .PARITY_ODD(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .enable_clk(enable_clk), .tx_valid(tx_valid2),
    .tx_data(tx_data), .tx_ready(tx_ready2), .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_tx(input bit sel);
    return sel ? tx2 : tx1;
  endfunction

  function automatic logic cur_done(input bit sel);
    return sel ? tx_done2 : tx_done1;
  endfunction

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one-cycle baud tick; returns at the negedge after the tick edge
  task automatic tick();
    enable_clk = 1'b1;
    @(negedge clk);
    enable_clk = 1'b0;
  endtask

  task automatic offer(input bit sel, input logic [7:0] d);
    int n;
    n = 0;
    tx_data = d;
    if (sel) tx_valid2 = 1'b1; else tx_valid = 1'b1;
    while (!(sel ? tx_ready2 : tx_ready1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("offer_wait", 32'(n < 200), 32'd1);
    @(negedge clk);
    tx_valid  = 1'b0;
    tx_valid2 = 1'b0;
    check("ready_after_accept", 32'(sel ? tx_ready2 : tx_ready1), 32'd0);
  endtask

  // called at the negedge just after the tick that began the start bit
  task automatic frame(input string tag, input bit sel, input logic [7:0] d,
                       input logic exp_par, input int nstop, input bit b2b);
    check({tag, "_start"}, 32'(cur_tx(sel)), 32'd0);
    for (int i = 0; i < 8; i++) begin
      gap(15); tick();
      check($sformatf("%s_d%0d", tag, i), 32'(cur_tx(sel)), 32'(d[i]));
    end
`ifdef UART_TX_PARITY_EN
    gap(15); tick();
    check({tag, "_parity"}, 32'(cur_tx(sel)), 32'(exp_par));
`else
    if (exp_par === 1'bx) $display("note: parity argument unset for %s", tag);
`endif
    for (int s = 0; s < nstop; s++) begin
      gap(15); tick();
      check($sformatf("%s_stop%0d", tag, s), 32'(cur_tx(sel)), 32'd1);
      check($sformatf("%s_nodone%0d", tag, s), 32'(cur_done(sel)), 32'd0);
    end
    gap(15); tick();
    check({tag, "_done"}, 32'(cur_done(sel)), 32'd1);
    check({tag, "_next_line"}, 32'(cur_tx(sel)), b2b ? 32'd0 : 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(cur_done(sel)), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    gap(3);
    rst_n = 1'b1;
    gap(2);
    check("rst_tx", 32'(tx1), 32'd1);
    check("rst_ready", 32'(tx_ready1), 32'd1);
    check("rst_busy", 32'(tx_busy1), 32'd0);
    check("rst_done", 32'(tx_done1), 32'd0);
    check("rst_tx2", 32'(tx2), 32'd1);

    // single byte 0x55
    offer(1'b0, 8'h55);
    check("idle_before_tick", 32'(tx1), 32'd1);
    gap(15); tick();
    check("busy_in_frame", 32'(tx_busy1), 32'd1);
    frame("b55", 1'b0, 8'h55, 1'b0, 1, 1'b0);
    check("busy_after_frame", 32'(tx_busy1), 32'd0);

    // 0xA5 then 0x3C, second held while the buffer is full
    offer(1'b0, 8'hA5);
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("ready_held_low", 32'(tx_ready1), 32'd0);
    end
    gap(10); tick();
    check("ready_after_unload", 32'(tx_ready1), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
    check("ready_second_accept", 32'(tx_ready1), 32'd0);
    frame("bA5", 1'b0, 8'hA5, 1'b0, 1, 1'b1);
    frame("b3C", 1'b0, 8'h3C, 1'b0, 1, 1'b0);

    // two stop bits, odd parity instance
    offer(1'b1, 8'hFF);
    gap(15); tick();
    frame("bFF_2stop", 1'b1, 8'hFF, 1'b1, 2, 1'b0);

    // parity sense on 0x07
    offer(1'b0, 8'h07);
    gap(15); tick();
    frame("b07_even", 1'b0, 8'h07, 1'b1, 1, 1'b0);
    offer(1'b1, 8'h07);
    gap(15); tick();
    frame("b07_odd", 1'b1, 8'h07, 1'b0, 2, 1'b0);

    // reset during data bit 4 of 0x00
    offer(1'b0, 8'h00);
    gap(15); tick();
    for (int i = 0; i < 5; i++) begin
      gap(15); tick();
    end
    check("pre_reset_bit4", 32'(tx1), 32'd0);
    gap(7);
    #2 rst_n = 1'b0;
    #1 check("reset_async_tx", 32'(tx1), 32'd1);
    gap(2);
    rst_n = 1'b1;
    check("reset_ready", 32'(tx_ready1), 32'd1);
    check("reset_busy", 32'(tx_busy1), 32'd0);
    for (int i = 0; i < 4; i++) begin
      gap(15); tick();
      check("reset_no_done", 32'(tx_done1), 32'd0);
      check("reset_line_idle", 32'(tx1), 32'd1);
    end
    offer(1'b0, 8'hC3);
    gap(15); tick();
    frame("bC3_after_reset", 1'b0, 8'hC3, 1'b0, 1, 1'b0);

    // stall in START for 100 cycles, second byte accepted meanwhile
    offer(1'b0, 8'h81);
    gap(15); tick();
    for (int c = 0; c < 100; c++) begin
      if (c == 30) begin
        tx_data  = 8'h42;
        tx_valid = 1'b1;
      end
      if (c == 31) tx_valid = 1'b0;
      @(negedge clk);
      if (c % 10 == 9) check("stall_start_low", 32'(tx1), 32'd0);
    end
    check("stall_buffer_filled", 32'(tx_ready1), 32'd0);
    check("stall_busy", 32'(tx_busy1), 32'd1);
    frame("b81_stall", 1'b0, 8'h81, 1'b0, 1, 1'b1);
    frame("b42_follow", 1'b0, 8'h42, 1'b0, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
